uart_tx_arb: RTL and testbench
==============================

// Module: uart_tx_arb
// PURPOSE
//  Packet-level round-robin arbiter sharing one uart_tx instance among N requesters.
//  Each requester streams bytes with a last flag. The grant is held until the byte flagged
//  last has been handed to uart_tx, so packets never interleave on the line.
//  Sits between requester logic and uart_tx: drives its wr_en/byte and watches its empty.
// PARAMETERS
//  N        4      number of requesters (2..8)
//  TIMEOUT  1024   stall cycles before a silent grant holder is dropped (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk       in   1     system clock
//  rst       in   1     reset, asynchronous, active-low
//  req       in   N     req[i]=1: requester i presents a valid byte on data[8*i+:8]
//  data      in   8*N   packed requester bytes; held stable while req[i]=1 and ack[i]=0
//  last      in   N     last[i]=1: current byte of requester i ends its packet
//  ack       out  N     one-cycle pulse: byte of requester i accepted; present next byte after it
//  grant     out  N     one-hot owner of the transmitter; 0 when idle
//  busy      out  1     1 while any grant is held
//  err       out  1     one-cycle pulse on timeout release (tied 0 without macro)
//  tx_wr_en  out  1     to uart_tx wr_en; one-cycle pulse
//  tx_byte   out  8     to uart_tx byte; valid while tx_wr_en=1, holds last value otherwise
//  tx_empty  in   1     from uart_tx empty; 1 = ready for a new byte
// BEHAVIOUR
//  - All outputs registered. Reset (rst=0, async): state IDLE, grant=0, ack=0, tx_wr_en=0,
//    tx_byte=8'h00, busy=0, err=0, rr pointer=0, last_q=0, counters=0.
//  - States: IDLE, LOAD, SETTLE, WAIT.
//  - IDLE: when |req and tx_empty=1, grant the first i with req[i]=1, searching rr, rr+1, ...
//    (mod N). grant<=onehot(i), busy<=1, goto LOAD. Otherwise stay.
//  - LOAD: if req[g]=1: on this edge tx_wr_en<=1, tx_byte<=data[g], ack[g]<=1, last_q<=last[g];
//    goto SETTLE. If req[g]=0: stay in LOAD, grant held (mid-packet stall).
//  - SETTLE: exactly 2 cycles; tx_wr_en and ack clear after the first. Tolerates empty
//    falling up to 2 cycles after wr_en. tx_empty is ignored here.
//  - WAIT: wait for tx_empty=1. Then if last_q=1: grant<=0, busy<=0, rr<=(g+1) mod N,
//    goto IDLE. Otherwise goto LOAD.
//  - Byte latency: req[g] high in LOAD -> tx_wr_en high 1 cycle later. Per-byte overhead is
//    1 LOAD + 2 SETTLE cycles plus the uart_tx frame time.
//  - tx_wr_en is never asserted while tx_empty=0, and is never high for 2 consecutive cycles.
//  - Single-byte packet (last=1 on the first byte) is legal: LOAD->SETTLE->WAIT->IDLE.
//  - Simultaneous requests: rr order decides. After a packet completes, its owner has the
//    lowest priority. A requester asserting req mid-packet of another waits; no starvation.
//  - Changes on req/data of non-granted requesters are ignored.
//  - Reset mid-operation: everything returns to reset values immediately. The partial packet
//    is abandoned; uart_tx shares rst and also aborts.
//  - rr is ceil(log2 N) bits; wrap from N-1 to 0.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//    - Stall counter (clog2(TIMEOUT+1) bits) counts cycles in LOAD with req[g]=0 and clears
//      on any accepted byte.
//    - Reaching TIMEOUT: grant<=0, busy<=0, err<=1 for one cycle, rr<=(g+1) mod N, goto IDLE.
//  UART_ARB_TIMEOUT_EN undefined:
//    - No counter. LOAD waits indefinitely for req[g]. err is constant 0.
// TESTING
//  1 Reset: rst=0 mid-WAIT -> same cycle grant=0, tx_wr_en=0, busy=0. After release,
//    idle with req=0 -> no tx_wr_en.
//  2 Single requester: req[0] streams 8'h59, 8'h0A(last) -> exactly 2 tx_wr_en pulses,
//    bytes 59, 0A in order, 2 ack[0] pulses, each wr_en only when tx_empty=1, grant released.
//  3 Contention: req=4'b1111, each requester sends a 3-byte packet -> packets emitted whole
//    in order 0,1,2,3; no interleave; rr=0 afterwards.
//  4 Fairness: req[0] re-requests right after its packet while req[2] pending ->
//    grant[2] precedes the next grant[0].
//  5 Mid-packet stall: requester 1 drops req for 50 cycles after byte 1 of 2 -> grant[1]
//    held, no tx_wr_en, other requesters blocked. Packet then completes.
//  6 Timeout (macro on, TIMEOUT=16): requester 3 drops req after a non-last byte ->
//    err pulse 16 cycles into LOAD stall, grant=0, next pending requester granted.
//    Macro off -> grant held indefinitely, err=0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter that shares one uart_tx among N requesters.
// Optional stall timeout on the grant holder is enabled with UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data,
  input  logic [N-1:0]   last,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           err,
  output logic           tx_wr_en,
  output logic [7:0]     tx_byte,
  input  logic           tx_empty
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_WAIT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   gidx_q, gidx_d;
  logic [W-1:0]   rr_q, rr_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           tx_wr_en_q, tx_wr_en_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           busy_q, busy_d;
  logic           last_q, last_d;
  logic           settle_q, settle_d;

  logic           found;
  logic [W-1:0]   pick;
  logic [W-1:0]   rr_next;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]  stall_q, stall_d;
  logic           err_q, err_d;
`endif

  // Round-robin search starting at rr_q, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(rr_q) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = W'(idx);
      end
    end
  end

  assign rr_next = (gidx_q == W'(N - 1)) ? '0 : gidx_q + W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    ack_d      = '0;
    tx_wr_en_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    last_d     = last_q;
    settle_d   = settle_q;
`ifdef UART_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found && tx_empty) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          gidx_d        = pick;
          busy_d        = 1'b1;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req[gidx_q]) begin
          tx_wr_en_d    = 1'b1;
          tx_byte_d     = data[{gidx_q, 3'b000} +: 8];
          ack_d[gidx_q] = 1'b1;
          last_d        = last[gidx_q];
          settle_d      = 1'b0;
          state_d       = S_SETTLE;
`ifdef UART_ARB_TIMEOUT_EN
          stall_d       = '0;
`endif
        end
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          stall_d = stall_q + SW'(1);
          if (stall_d == SW'(TIMEOUT)) begin
            stall_d = '0;
            grant_d = '0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            rr_d    = rr_next;
            state_d = S_IDLE;
          end
        end
`endif
      end
      // Two fixed cycles so uart_tx has time to drop empty after the write.
      S_SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_empty) begin
          if (last_q) begin
            grant_d = '0;
            busy_d  = 1'b0;
            rr_d    = rr_next;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_q       <= '0;
      ack_q      <= '0;
      tx_wr_en_q <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      last_q     <= 1'b0;
      settle_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      tx_wr_en_q <= tx_wr_en_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      settle_q   <= settle_d;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q    <= stall_d;
      err_q      <= err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign tx_wr_en = tx_wr_en_q;
  assign tx_byte  = tx_byte_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: requester queues, a simple uart_tx empty model,
// and an output log compared against hand-computed byte/source sequences.
module tb_uart_tx_arb;

  localparam int unsigned FRAME = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  last = '0;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        err;
  logic        tx_wr_en;
  logic [7:0]  tx_byte;
  logic        tx_empty = 1'b1;

  uart_tx_arb #(.N(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
    .ack(ack), .grant(grant), .busy(busy), .err(err),
    .tx_wr_en(tx_wr_en), .tx_byte(tx_byte), .tx_empty(tx_empty)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  rbyte [4][16];
  logic        rlast [4][16];
  int unsigned rhead [4];
  int unsigned rtail [4];
  logic [7:0]  obyte [64];
  int unsigned osrc  [64];
  int unsigned n_out = 0;
  int unsigned ack_cnt [4];
  logic        prev_wr = 1'b0;
  int unsigned busy_cnt = 0;
  int unsigned base;
  int unsigned acks0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned STALL = 10;
`else
  localparam int unsigned STALL = 50;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 99;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rhead[i] < rtail[i]) begin
        req[i]         = 1'b1;
        data[8*i +: 8] = rbyte[i][rhead[i]];
        last[i]        = rlast[i][rhead[i]];
      end else begin
        req[i]  = 1'b0;
        last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    rbyte[i][rtail[i]] = b;
    rlast[i][rtail[i]] = l;
    rtail[i]++;
    drive();
  endtask

  // One clock: per-cycle protocol checks, output logging, uart model, requester advance.
  task automatic tick();
    @(posedge clk);
    #1;
    check("ack_vs_wr", {28'h0, ack}, tx_wr_en ? {28'h0, grant} : 32'h0);
    check("wr_back_to_back", {31'h0, prev_wr & tx_wr_en}, 32'h0);
`ifndef UART_ARB_TIMEOUT_EN
    check("err_zero", {31'h0, err}, 32'h0);
`endif
    if (tx_wr_en) begin
      check("wr_while_not_empty", {31'h0, tx_empty}, 32'h1);
      obyte[n_out] = tx_byte;
      osrc[n_out]  = onehot_idx(grant);
      n_out++;
      tx_empty = 1'b0;
      busy_cnt = FRAME;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_empty = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) begin
        ack_cnt[i]++;
        if (rhead[i] < rtail[i]) rhead[i]++;
      end
    end
    prev_wr = tx_wr_en;
    drive();
  endtask

  task automatic wait_out(input int unsigned target, input string tag);
    int unsigned t;
    t = 0;
    while (n_out < target && t < 3000) begin
      tick();
      t++;
    end
    check({tag, "_wait_bound"}, {31'h0, (t < 3000)}, 32'h1);
  endtask

  task automatic run_until(input int unsigned target, input string tag);
    int unsigned t;
    t = 0;
    while (!(n_out >= target && busy === 1'b0 && tx_empty) && t < 3000) begin
      tick();
      t++;
    end
    check({tag, "_run_bound"}, {31'h0, (t < 3000)}, 32'h1);
  endtask

  task automatic check_out(input int unsigned k, input logic [7:0] b, input int unsigned s);
    check($sformatf("byte%0d", k), {24'h0, obyte[k]}, {24'h0, b});
    check($sformatf("src%0d", k), osrc[k], s);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    drive();
    tx_empty = 1'b1;
    busy_cnt = 0;
    prev_wr  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rhead[i]   = 0;
      rtail[i]   = 0;
      ack_cnt[i] = 0;
    end
    #2;
    check("rst_grant", {28'h0, grant}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_wr", {31'h0, tx_wr_en}, 32'h0);
    check("rst_ack", {28'h0, ack}, 32'h0);
    check("rst_byte", {24'h0, tx_byte}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Reset asserted while waiting on the frame of a granted byte.
    push(0, 8'h33, 1'b1);
    wait_out(1, "t1");
    tick(); tick(); tick();
    check("t1_busy_before", {31'h0, busy}, 32'h1);
    check("t1_grant_before", {28'h0, grant}, 32'h1);
    rst = 1'b0;
    #1;
    check("t1_grant_async", {28'h0, grant}, 32'h0);
    check("t1_busy_async", {31'h0, busy}, 32'h0);
    check("t1_wr_async", {31'h0, tx_wr_en}, 32'h0);
    check("t1_byte_async", {24'h0, tx_byte}, 32'h0);
    do_reset();
    base = n_out;
    for (int c = 0; c < 10; c++) tick();
    check("t1_idle_no_wr", n_out, base);
    check("t1_idle_grant", {28'h0, grant}, 32'h0);

    // Single requester, two-byte packet.
    base  = n_out;
    acks0 = ack_cnt[0];
    push(0, 8'h59, 1'b0);
    push(0, 8'h0A, 1'b1);
    run_until(base + 2, "t2");
    check("t2_count", n_out - base, 2);
    check_out(base, 8'h59, 0);
    check_out(base + 1, 8'h0A, 0);
    check("t2_acks", ack_cnt[0] - acks0, 2);
    check("t2_grant_released", {28'h0, grant}, 32'h0);
    check("t2_byte_held", {24'h0, tx_byte}, 32'h0A);

    // Full contention from rr=0: whole packets in order 0,1,2,3.
    do_reset();
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      push(i, 8'h10 + 8'(16 * i), 1'b0);
      push(i, 8'h11 + 8'(16 * i), 1'b0);
      push(i, 8'h12 + 8'(16 * i), 1'b1);
    end
    run_until(base + 12, "t3");
    check("t3_count", n_out - base, 12);
    check_out(base + 0, 8'h10, 0);  check_out(base + 1, 8'h11, 0);  check_out(base + 2, 8'h12, 0);
    check_out(base + 3, 8'h20, 1);  check_out(base + 4, 8'h21, 1);  check_out(base + 5, 8'h22, 1);
    check_out(base + 6, 8'h30, 2);  check_out(base + 7, 8'h31, 2);  check_out(base + 8, 8'h32, 2);
    check_out(base + 9, 8'h40, 3);  check_out(base + 10, 8'h41, 3); check_out(base + 11, 8'h42, 3);

    // Fairness: requester 0 re-requests immediately; pending requester 2 goes first.
    base = n_out;
    push(0, 8'h50, 1'b0);
    push(0, 8'h51, 1'b1);
    push(0, 8'h52, 1'b1);
    push(2, 8'h70, 1'b1);
    run_until(base + 4, "t4");
    check("t4_count", n_out - base, 4);
    check_out(base + 0, 8'h50, 0);
    check_out(base + 1, 8'h51, 0);
    check_out(base + 2, 8'h70, 2);
    check_out(base + 3, 8'h52, 0);

    // Mid-packet stall of requester 1 blocks requester 3.
    base = n_out;
    push(1, 8'h81, 1'b0);
    push(3, 8'h90, 1'b1);
    wait_out(base + 1, "t5");
    for (int c = 0; c < STALL; c++) begin
      tick();
      check("t5_grant_held", {28'h0, grant}, 32'h2);
      check("t5_no_wr", n_out, base + 1);
    end
    push(1, 8'h82, 1'b1);
    run_until(base + 3, "t5b");
    check("t5_count", n_out - base, 3);
    check_out(base + 0, 8'h81, 1);
    check_out(base + 1, 8'h82, 1);
    check_out(base + 2, 8'h90, 3);

    // Requester 3 goes silent after a non-last byte.
    base = n_out;
    push(3, 8'hA1, 1'b0);
    wait_out(base + 1, "t6");
    push(0, 8'hB1, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int unsigned t;
      t = 0;
      while (!tx_empty && t < 100) begin
        tick();
        t++;
      end
      check("t6_empty_bound", {31'h0, (t < 100)}, 32'h1);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      check("t6_err_early", {31'h0, err}, 32'h0);
      check("t6_grant_stall", {28'h0, grant}, 32'h8);
    end
    tick();
    check("t6_err_pulse", {31'h0, err}, 32'h1);
    check("t6_grant_drop", {28'h0, grant}, 32'h0);
    check("t6_busy_drop", {31'h0, busy}, 32'h0);
    run_until(base + 2, "t6b");
    push(3, 8'hA2, 1'b1);
    run_until(base + 3, "t6c");
    check_out(base + 0, 8'hA1, 3);
    check_out(base + 1, 8'hB1, 0);
    check_out(base + 2, 8'hA2, 3);
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      check("t6_grant_held", {28'h0, grant}, 32'h8);
      check("t6_no_wr", n_out, base + 1);
    end
    push(3, 8'hA2, 1'b1);
    run_until(base + 3, "t6b");
    check_out(base + 0, 8'hA1, 3);
    check_out(base + 1, 8'hA2, 3);
    check_out(base + 2, 8'hB1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
